// File: rtl/pf_ddr4_train_pkg.sv
// ---------------------------------------------------------------------------
// pf_ddr4_train_pkg
// Shared types and constants for the DDR4 DQSW write-leveling controller:
// FSM state encoding, failure codes and the DQS pulse pattern driven into
// the lane's TX/OE path.
// ---------------------------------------------------------------------------
package pf_ddr4_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_PULSE,
    ST_WAIT,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_DONE,
    ST_FAIL
  } train_state_e;

  localparam logic [1:0] FAIL_NONE         = 2'b00;
  localparam logic [1:0] FAIL_NO_EDGE      = 2'b01;
  localparam logic [1:0] FAIL_OUT_OF_RANGE = 2'b10;

  localparam logic [1:0] DQS_PULSE_TX = 2'b01;
  localparam logic [1:0] DQS_PULSE_OE = 2'b11;
  localparam logic [1:0] DQS_IDLE     = 2'b00;

  // True while a training pass is actively driving the delay line, i.e. in
  // the states where an out-of-range report from the IOD must abort.
  function automatic logic oor_watched(input train_state_e s);
    return !((s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DONE) || (s == ST_FAIL));
  endfunction

  // True from LOAD through STEP: the training pass owns the lane.
  function automatic logic train_active(input train_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL));
  endfunction

endpackage

// File: rtl/pf_ddr4_train_vote.sv
// ---------------------------------------------------------------------------
// pf_ddr4_train_vote
// Majority voter over SAMPLES feedback bits taken at one tap.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - zero the vote count (start of a tap)
//   sample_en   - accumulate bit_in this cycle
//   bit_in      - DQ feedback bit
//   fb          - 1 when strictly more than half of the samples were 1
// ---------------------------------------------------------------------------
module pf_ddr4_train_vote
  import pf_ddr4_train_pkg::*;
#(
  parameter int SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_en,
  input  logic bit_in,
  output logic fb
);

  localparam int VW = $clog2(SAMPLES + 1);
  localparam logic [VW-1:0] VOTE_MAX  = VW'(SAMPLES);
  localparam logic [VW-1:0] VOTE_HALF = VW'(SAMPLES / 2);

  logic [VW-1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (clear) begin
      vote_d = '0;
    end else if (sample_en && bit_in && (vote_q != VOTE_MAX)) begin
      // saturate so the count can never wrap back to a low value
      vote_d = vote_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vote_q <= '0;
    else        vote_q <= vote_d;
  end

  assign fb = (vote_q > VOTE_HALF);

endmodule

// File: rtl/pf_ddr4_dqsw_train_ctrl.sv
// ---------------------------------------------------------------------------
// pf_ddr4_dqsw_train_ctrl
// Write-leveling (DQSW) training controller for one DDR4 lane. Fires single
// DQS pulses through the IOD, majority-votes the DQ feedback at each delay
// tap, and locks the first tap where feedback goes 0 -> 1.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for TRAIN_START
// LOAD   | reload delay line to static value, clear tap/vote/seen_zero
// CLR    | clear eye monitor flags
// PULSE  | drive one DQS pulse
// WAIT   | SETTLE_CYC cycles for feedback to return
// SAMPLE | accumulate RX_DATA[0] into the vote
// EVAL   | decide feedback for this tap
// STEP   | move delay line one tap, or fail at the last tap
// DONE   | tap locked, TAP_RESULT valid
// FAIL   | training failed, FAIL_CODE valid
//
// Ports:
//   FAB_CLK, ARST_N               clock, async active-low reset
//   TRAIN_START/BUSY/DONE/FAIL    sequencer handshake
//   FAIL_CODE, TAP_RESULT         result
//   DELAY_LINE_*                  IOD delay line control / status
//   EYE_MONITOR_CLEAR_FLAGS       IOD eye monitor clear pulse
//   TX_DATA, OE_DATA, ODT_EN      IOD DQS drive
//   RX_DATA                       DQ feedback (bit 0 used)
// ---------------------------------------------------------------------------
module pf_ddr4_dqsw_train_ctrl
  import pf_ddr4_train_pkg::*;
#(
  parameter int TAP_W      = 8,
  parameter int MAX_TAPS   = 128,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLES    = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             TRAIN_START,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL,
  output logic [1:0]       FAIL_CODE,
  output logic [TAP_W-1:0] TAP_RESULT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic [1:0]       TX_DATA,
  output logic [1:0]       OE_DATA,
  output logic             ODT_EN,
  input  logic [1:0]       RX_DATA
);

  localparam int SW = $clog2(SAMPLES + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [TAP_W-1:0] TAP_LAST     = TAP_W'(MAX_TAPS - 1);
  localparam logic [SW-1:0]    SAMPLE_LAST  = SW'(SAMPLES - 1);
  localparam logic [CW-1:0]    SETTLE_START = CW'(SETTLE_CYC - 1);

  train_state_e     state_q, state_d;
  logic [TAP_W-1:0] tap_cnt_q, tap_cnt_d;
  logic             seen_zero_q, seen_zero_d;
  logic [SW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [TAP_W-1:0] tap_result_q, tap_result_d;

  logic       vote_clear;
  logic       vote_en;
  logic       vote_fb;
  logic       oor_hit;
  logic       load_pulse;
  logic       move_pulse;
  logic       clr_pulse;
  logic [1:0] tx_data;
  logic [1:0] oe_data;
  logic       rx_unused;

  assign rx_unused = RX_DATA[1];

  pf_ddr4_train_vote #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk       (FAB_CLK),
    .rst_n     (ARST_N),
    .clear     (vote_clear),
    .sample_en (vote_en),
    .bit_in    (RX_DATA[0]),
    .fb        (vote_fb)
  );

  always_comb begin
    state_d      = state_q;
    tap_cnt_d    = tap_cnt_q;
    seen_zero_d  = seen_zero_q;
    sample_cnt_d = sample_cnt_q;
    settle_d     = settle_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    tap_result_d = tap_result_q;
    vote_clear   = 1'b0;
    vote_en      = 1'b0;
    load_pulse   = 1'b0;
    move_pulse   = 1'b0;
    clr_pulse    = 1'b0;
    tx_data      = DQS_IDLE;
    oe_data      = DQS_IDLE;
    oor_hit      = DELAY_LINE_OUT_OF_RANGE && oor_watched(state_q);

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (TRAIN_START) begin
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_code_d  = FAIL_NONE;
          tap_result_d = '0;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_pulse   = 1'b1;
        tap_cnt_d    = '0;
        seen_zero_d  = 1'b0;
        sample_cnt_d = '0;
        vote_clear   = 1'b1;
        state_d      = ST_CLR;
      end
      ST_CLR: begin
        clr_pulse = 1'b1;
        state_d   = ST_PULSE;
      end
      ST_PULSE: begin
        tx_data  = DQS_PULSE_TX;
        oe_data  = DQS_PULSE_OE;
        settle_d = SETTLE_START;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_q == '0) state_d = ST_SAMPLE;
        else                settle_d = settle_q - 1'b1;
      end
      ST_SAMPLE: begin
        vote_en      = 1'b1;
        sample_cnt_d = sample_cnt_q + 1'b1;
        state_d      = (sample_cnt_q == SAMPLE_LAST) ? ST_EVAL : ST_PULSE;
      end
      ST_EVAL: begin
        if (!vote_fb) begin
          seen_zero_d = 1'b1;
          state_d     = ST_STEP;
        end else if (seen_zero_q) begin
          tap_result_d = tap_cnt_q;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end else begin
          // feedback already high before any low region: keep stepping
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (tap_cnt_q == TAP_LAST) begin
          fail_d      = 1'b1;
          fail_code_d = FAIL_NO_EDGE;
          state_d     = ST_FAIL;
        end else begin
          move_pulse   = 1'b1;
          tap_cnt_d    = tap_cnt_q + 1'b1;
          sample_cnt_d = '0;
          vote_clear   = 1'b1;
          state_d      = ST_PULSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range overrides whatever the state decided this cycle,
    // including a lock in EVAL and a move in STEP.
    if (oor_hit) begin
      move_pulse   = 1'b0;
      done_d       = 1'b0;
      tap_result_d = tap_result_q;
      fail_d       = 1'b1;
      fail_code_d  = FAIL_OUT_OF_RANGE;
      state_d      = ST_FAIL;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= ST_IDLE;
      tap_cnt_q    <= '0;
      seen_zero_q  <= 1'b0;
      sample_cnt_q <= '0;
      settle_q     <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FAIL_NONE;
      tap_result_q <= '0;
    end else begin
      state_q      <= state_d;
      tap_cnt_q    <= tap_cnt_d;
      seen_zero_q  <= seen_zero_d;
      sample_cnt_q <= sample_cnt_d;
      settle_q     <= settle_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      tap_result_q <= tap_result_d;
    end
  end

  assign TRAIN_BUSY              = train_active(state_q);
  assign TRAIN_DONE              = done_q;
  assign TRAIN_FAIL              = fail_q;
  assign FAIL_CODE               = fail_code_q;
  assign TAP_RESULT              = tap_result_q;
  assign DELAY_LINE_LOAD         = load_pulse;
  assign DELAY_LINE_MOVE         = move_pulse;
  assign DELAY_LINE_DIRECTION    = train_active(state_q);
  assign EYE_MONITOR_CLEAR_FLAGS = clr_pulse;
  assign TX_DATA                 = tx_data;
  assign OE_DATA                 = oe_data;
  assign ODT_EN                  = !train_active(state_q);

endmodule

// File: tb/tb_pf_ddr4_dqsw_train_ctrl.sv
// Scoreboarded bench for pf_ddr4_dqsw_train_ctrl with a behavioural IOD
// model that returns feedback as a function of the current delay tap.
module tb_pf_ddr4_dqsw_train_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       TRAIN_START = 1'b0;
  logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL;
  logic [1:0] FAIL_CODE;
  logic [7:0] TAP_RESULT;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic [1:0] TX_DATA, OE_DATA;
  logic       ODT_EN;
  logic [1:0] RX_DATA;

  always #5 FAB_CLK = ~FAB_CLK;

  pf_ddr4_dqsw_train_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .TRAIN_START             (TRAIN_START),
    .TRAIN_BUSY              (TRAIN_BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_FAIL              (TRAIN_FAIL),
    .FAIL_CODE               (FAIL_CODE),
    .TAP_RESULT              (TAP_RESULT),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .TX_DATA                 (TX_DATA),
    .OE_DATA                 (OE_DATA),
    .ODT_EN                  (ODT_EN),
    .RX_DATA                 (RX_DATA)
  );

  typedef struct {
    logic       done;
    logic       fail;
    logic [1:0] code;
    logic [7:0] tap;
    int         moves;
    int         loads;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int mode = 0;
  int tap_m = 0;
  int pidx_m = 0;
  int loads_m = 0;

  // Feedback seen by the DQ pin: md selects the scenario, t is the tap,
  // k the sample index within the tap.
  function automatic logic fb_model(input int md, input int t, input int k);
    case (md)
      1: return (t >= 37);
      2: return (t < 10) || (t >= 20);
      5: begin
        if (t < 5)       return 1'b0;
        else if (t == 5) return (k == 0) || (k == 2);
        else             return (k != 2);
      end
      default: return 1'b0;
    endcase
  endfunction

  // Bit 1 is held high so that any use of it by the DUT would show up.
  assign RX_DATA = {1'b1, fb_model(mode, tap_m, pidx_m - 1)};

  always @(negedge FAB_CLK) begin
    if (DELAY_LINE_LOAD) begin
      tap_m   <= 0;
      pidx_m  <= 0;
      loads_m <= loads_m + 1;
    end else if (DELAY_LINE_MOVE) begin
      tap_m  <= tap_m + 1;
      pidx_m <= 0;
    end else if (OE_DATA == 2'b11) begin
      pidx_m <= pidx_m + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation each time the DUT reports completion.
  logic prev_end = 1'b0;
  always @(negedge FAB_CLK) begin
    logic end_now;
    exp_t e;
    end_now = TRAIN_DONE | TRAIN_FAIL;
    if (end_now && !prev_end) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done", int'(TRAIN_DONE), int'(e.done));
        chk("fail", int'(TRAIN_FAIL), int'(e.fail));
        chk("fail_code", int'(FAIL_CODE), int'(e.code));
        if (e.done) chk("tap_result", int'(TAP_RESULT), int'(e.tap));
        chk("move_count", tap_m, e.moves);
        chk("load_count", loads_m, e.loads);
      end
    end
    prev_end = end_now;
  end

  function automatic exp_t mk(input logic d, input logic f, input logic [1:0] c,
                              input logic [7:0] t, input int mv, input int ld);
    exp_t e;
    e.done = d; e.fail = f; e.code = c; e.tap = t; e.moves = mv; e.loads = ld;
    return e;
  endfunction

  task automatic pulse_start();
    @(posedge FAB_CLK); #1 TRAIN_START = 1'b1;
    @(posedge FAB_CLK); #1 TRAIN_START = 1'b0;
  endtask

  task automatic start_train(input int md, input exp_t e);
    mode = md;
    exp_q.push_back(e);
    pulse_start();
  endtask

  task automatic wait_end(input int extra_start_at);
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge FAB_CLK); #1;
      TRAIN_START = (i == extra_start_at);
      if (i == 2) begin
        chk("busy_mid", int'(TRAIN_BUSY), 1);
        chk("dir_mid", int'(DELAY_LINE_DIRECTION), 1);
        chk("odt_mid", int'(ODT_EN), 0);
      end
      if (!TRAIN_BUSY && (TRAIN_DONE || TRAIN_FAIL)) begin
        ended = 1'b1;
        break;
      end
    end
    TRAIN_START = 1'b0;
    if (!ended) chk("completion_timeout", 0, 1);
    @(negedge FAB_CLK);
    @(negedge FAB_CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(TRAIN_BUSY), 0);
    chk({tag, "_done"}, int'(TRAIN_DONE), 0);
    chk({tag, "_fail"}, int'(TRAIN_FAIL), 0);
    chk({tag, "_code"}, int'(FAIL_CODE), 0);
    chk({tag, "_tap"}, int'(TAP_RESULT), 0);
    chk({tag, "_load"}, int'(DELAY_LINE_LOAD), 0);
    chk({tag, "_move"}, int'(DELAY_LINE_MOVE), 0);
    chk({tag, "_dir"}, int'(DELAY_LINE_DIRECTION), 0);
    chk({tag, "_clr"}, int'(EYE_MONITOR_CLEAR_FLAGS), 0);
    chk({tag, "_tx"}, int'(TX_DATA), 0);
    chk({tag, "_oe"}, int'(OE_DATA), 0);
    chk({tag, "_odt"}, int'(ODT_EN), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;

    #23;
    chk_reset_vals("reset");
    ARST_N = 1'b1;
    repeat (2) @(posedge FAB_CLK);

    // 1: edge at tap 37
    start_train(1, mk(1, 0, 2'b00, 8'd37, 37, loads_m + 1));
    wait_end(-1);

    // 2: early high region ignored, edge at tap 20
    start_train(2, mk(1, 0, 2'b00, 8'd20, 20, loads_m + 1));
    wait_end(-1);

    // 3: never rises, fail with no move at the last tap
    start_train(3, mk(0, 1, 2'b01, 8'd0, 127, loads_m + 1));
    wait_end(-1);

    // 4: out-of-range at tap 50
    start_train(3, mk(0, 1, 2'b10, 8'd0, 50, loads_m + 1));
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge FAB_CLK);
      if (tap_m == 50) begin hit = 1'b1; break; end
    end
    if (!hit) chk("reach_tap50_timeout", 0, 1);
    @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    @(posedge FAB_CLK); #1;
    chk("oor_fail_1cyc", int'(TRAIN_FAIL), 1);
    chk("oor_code_1cyc", int'(FAIL_CODE), 2);
    wait_end(-1);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;

    // 5: noisy votes (2/4 -> 0, 3/4 -> 1) and an ignored start while busy
    start_train(5, mk(1, 0, 2'b00, 8'd6, 6, loads_m + 1));
    wait_end(100);

    // 6: async reset mid-WAIT, then a clean rerun of scenario 1
    mode = 1;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge FAB_CLK);
      if (OE_DATA == 2'b11) begin hit = 1'b1; break; end
    end
    if (!hit) chk("pulse_seen_timeout", 0, 1);
    repeat (3) @(posedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (3) begin
      @(negedge FAB_CLK);
      chk("reset_hold_move", int'(DELAY_LINE_MOVE), 0);
      chk("reset_hold_load", int'(DELAY_LINE_LOAD), 0);
    end
    #2 ARST_N = 1'b1;
    repeat (2) @(posedge FAB_CLK);
    start_train(1, mk(1, 0, 2'b00, 8'd37, 37, loads_m + 1));
    wait_end(-1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
